// File: rtl/cam_action_stage_if.sv
// Result path between the CAM-facing input and the forwarding consumer.
// The master drives match indices and ready. The slave returns the head result.
interface cam_action_stage_if #(
  parameter int ACT_W = 8
);
  logic             idx_vld;
  logic [3:0]       idx;
  logic             act_vld;
  logic [3:0]       act_idx;
  logic [ACT_W-1:0] act_data;
  logic             act_rdy;

  modport master (
    output idx_vld, idx, act_rdy,
    input  act_vld, act_idx, act_data
  );

  modport slave (
    input  idx_vld, idx, act_rdy,
    output act_vld, act_idx, act_data
  );
endinterface

// File: rtl/cam_action_stage.sv
// Looks up the action for each CAM match index and buffers {index, action} in a
// first-word-fall-through FIFO. Results that arrive while the FIFO is full are dropped and counted.
module cam_action_stage #(
  parameter int ACT_W      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16,
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1,
  localparam int PTR_W     = $clog2(FIFO_DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  cam_action_stage_if.slave   bus,
  input  logic                cfg_wr_en,
  input  logic [3:0]          cfg_addr,
  input  logic [ACT_W-1:0]    cfg_data,
  output logic [LVL_W-1:0]    fifo_level,
  output logic [CNT_W-1:0]    drop_cnt
);

  logic [ACT_W-1:0] table_q [16];
  logic             l_vld_q;
  logic [3:0]       l_idx_q;
  logic [ACT_W-1:0] l_act_q;

  logic [3:0]       fifo_idx_q [FIFO_DEPTH];
  logic [ACT_W-1:0] fifo_act_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic             empty_s;
  logic             full_s;
  logic             pop_s;
  logic             push_s;
  logic             drop_s;

  // Action table and lookup stage; the non-blocking read gives a same-edge lookup the old entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        table_q[i] <= ACT_W'(i);
      end
      l_vld_q <= 1'b0;
      l_idx_q <= 4'd0;
      l_act_q <= '0;
    end else begin
      if (cfg_wr_en) begin
        table_q[cfg_addr] <= cfg_data;
      end
      l_vld_q <= bus.idx_vld;
      if (bus.idx_vld) begin
        l_idx_q <= bus.idx;
        l_act_q <= table_q[bus.idx];
      end
    end
  end

  // FIFO control; when full, a push is accepted only if a pop frees a slot on the same edge
  always_comb begin
    empty_s    = (level_q == LVL_W'(0));
    full_s     = (level_q == LVL_W'(FIFO_DEPTH));
    pop_s      = !empty_s && bus.act_rdy;
    push_s     = l_vld_q && (!full_s || pop_s);
    drop_s     = l_vld_q && !push_s;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    drop_cnt_d = drop_cnt_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    if (drop_s && (drop_cnt_q != {CNT_W{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // FIFO storage and state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_idx_q[i] <= 4'd0;
        fifo_act_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (push_s) begin
        fifo_idx_q[wr_ptr_q] <= l_idx_q;
        fifo_act_q[wr_ptr_q] <= l_act_q;
      end
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Head outputs come straight from storage; they are masked to zero when empty
  assign bus.act_vld  = !empty_s;
  assign bus.act_idx  = empty_s ? 4'd0 : fifo_idx_q[rd_ptr_q];
  assign bus.act_data = empty_s ? '0 : fifo_act_q[rd_ptr_q];
  assign fifo_level   = level_q;
  assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_cam_action_stage.sv
// Directed bench for cam_action_stage: reset, table programming, overflow,
// full push/pop, streaming and mid-stream reset.
module tb_cam_action_stage;
  logic       clk;
  logic       reset;
  logic       cfg_wr_en;
  logic [3:0] cfg_addr;
  logic [7:0] cfg_data;
  logic [2:0] fifo_level;
  logic [15:0] drop_cnt;
  logic [7:0] exp_tab [16];
  int total;
  int bad;

  cam_action_stage_if #(.ACT_W(8)) bus ();

  cam_action_stage #(.ACT_W(8), .FIFO_DEPTH(4), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .cfg_wr_en  (cfg_wr_en),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .fifo_level (fifo_level),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    total++; if (bus.act_vld !== 1'b0) begin bad++; $display("FAIL rst_vld got=%0b exp=0", bus.act_vld); end
    total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL rst_level got=%0d exp=0", fifo_level); end
    total++; if (drop_cnt !== 16'd0) begin bad++; $display("FAIL rst_drop got=%0d exp=0", drop_cnt); end
    total++; if (bus.act_idx !== 4'd0 || bus.act_data !== 8'd0) begin bad++; $display("FAIL rst_head got=%0h/%0h exp=0/0", bus.act_idx, bus.act_data); end
    reset = 1'b0;
    bus.act_rdy = 1'b1;
    bus.idx_vld = 1'b1; bus.idx = 4'd5;
    step;
    bus.idx_vld = 1'b0;
    total++; if (bus.act_vld !== 1'b0) begin bad++; $display("FAIL lat_early got=%0b exp=0", bus.act_vld); end
    step;
    total++; if (bus.act_vld !== 1'b1 || bus.act_idx !== 4'd5 || bus.act_data !== 8'h05) begin
      bad++; $display("FAIL lat_first got=%0b/%0h/%0h exp=1/5/05", bus.act_vld, bus.act_idx, bus.act_data); end
    total++; if (fifo_level !== 3'd1) begin bad++; $display("FAIL lat_level got=%0d exp=1", fifo_level); end
    step;
    total++; if (fifo_level !== 3'd0 || bus.act_vld !== 1'b0 || drop_cnt !== 16'd0) begin
      bad++; $display("FAIL lat_drain got=%0d/%0b/%0d exp=0/0/0", fifo_level, bus.act_vld, drop_cnt); end
  endtask

  task automatic test_table;
    cfg_wr_en = 1'b1; cfg_addr = 4'd3; cfg_data = 8'hA7; exp_tab[3] = 8'hA7;
    step;
    cfg_wr_en = 1'b0;
    bus.idx_vld = 1'b1; bus.idx = 4'd3;
    step;
    bus.idx_vld = 1'b0;
    step;
    total++; if (bus.act_idx !== 4'd3 || bus.act_data !== 8'hA7) begin
      bad++; $display("FAIL tbl_write got=%0h/%0h exp=3/a7", bus.act_idx, bus.act_data); end
    step;
    cfg_wr_en = 1'b1; cfg_addr = 4'd9; cfg_data = 8'h11; exp_tab[9] = 8'h11;
    bus.idx_vld = 1'b1; bus.idx = 4'd9;
    step;
    cfg_wr_en = 1'b0;
    step;
    bus.idx_vld = 1'b0;
    total++; if (bus.act_data !== 8'h09) begin bad++; $display("FAIL tbl_same_edge got=%0h exp=09", bus.act_data); end
    step;
    total++; if (bus.act_data !== 8'h11) begin bad++; $display("FAIL tbl_after got=%0h exp=11", bus.act_data); end
    step;
    total++; if (bus.act_vld !== 1'b0) begin bad++; $display("FAIL tbl_empty got=%0b exp=0", bus.act_vld); end
  endtask

  task automatic test_overflow;
    bus.act_rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.idx_vld = 1'b1; bus.idx = 4'(i);
      step;
    end
    bus.idx_vld = 1'b0;
    step;
    total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL ovf_level got=%0d exp=4", fifo_level); end
    total++; if (drop_cnt !== 16'd2) begin bad++; $display("FAIL ovf_drop got=%0d exp=2", drop_cnt); end
    step;
    total++; if (bus.act_idx !== 4'd0 || fifo_level !== 3'd4) begin
      bad++; $display("FAIL ovf_hold got=%0h/%0d exp=0/4", bus.act_idx, fifo_level); end
    bus.act_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      total++; if (bus.act_vld !== 1'b1 || bus.act_idx !== 4'(k) || bus.act_data !== exp_tab[k]) begin
        bad++; $display("FAIL ovf_order%0d got=%0b/%0h/%0h exp=1/%0h/%0h", k, bus.act_vld, bus.act_idx, bus.act_data, k, exp_tab[k]); end
      step;
    end
    total++; if (bus.act_vld !== 1'b0) begin bad++; $display("FAIL ovf_empty got=%0b exp=0", bus.act_vld); end
    bus.act_rdy = 1'b0;
  endtask

  task automatic test_full_pushpop;
    logic [3:0] exp_q [4];
    exp_q[0] = 4'd11; exp_q[1] = 4'd12; exp_q[2] = 4'd13; exp_q[3] = 4'd7;
    for (int i = 0; i < 4; i++) begin
      bus.idx_vld = 1'b1; bus.idx = 4'(10 + i);
      step;
    end
    bus.idx_vld = 1'b0;
    step;
    total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL fpp_fill got=%0d exp=4", fifo_level); end
    bus.idx_vld = 1'b1; bus.idx = 4'd7;
    step;
    bus.idx_vld = 1'b0; bus.act_rdy = 1'b1;
    step;
    bus.act_rdy = 1'b0;
    total++; if (fifo_level !== 3'd4 || drop_cnt !== 16'd2) begin
      bad++; $display("FAIL fpp_level got=%0d/%0d exp=4/2", fifo_level, drop_cnt); end
    bus.act_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      total++; if (bus.act_idx !== exp_q[k] || bus.act_data !== exp_tab[exp_q[k]]) begin
        bad++; $display("FAIL fpp_order%0d got=%0h/%0h exp=%0h/%0h", k, bus.act_idx, bus.act_data, exp_q[k], exp_tab[exp_q[k]]); end
      step;
    end
    total++; if (bus.act_vld !== 1'b0) begin bad++; $display("FAIL fpp_empty got=%0b exp=0", bus.act_vld); end
  endtask

  task automatic test_streaming;
    int rx;
    rx = 0;
    bus.act_rdy = 1'b1;
    for (int c = 0; c < 36; c++) begin
      bus.idx_vld = (c < 32) ? 1'b1 : 1'b0;
      bus.idx = 4'(c % 16);
      step;
      total++; if (fifo_level > 3'd1) begin bad++; $display("FAIL strm_level got=%0d exp<=1", fifo_level); end
      if (bus.act_vld === 1'b1) begin
        total++; if (bus.act_idx !== 4'(rx % 16) || bus.act_data !== exp_tab[rx % 16]) begin
          bad++; $display("FAIL strm_data%0d got=%0h/%0h exp=%0h/%0h", rx, bus.act_idx, bus.act_data, rx % 16, exp_tab[rx % 16]); end
        rx++;
      end
    end
    total++; if (rx != 32) begin bad++; $display("FAIL strm_count got=%0d exp=32", rx); end
    total++; if (drop_cnt !== 16'd2) begin bad++; $display("FAIL strm_drop got=%0d exp=2", drop_cnt); end
  endtask

  task automatic test_reset_mid;
    bus.act_rdy = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      bus.idx_vld = 1'b1; bus.idx = 4'(i);
      step;
    end
    bus.idx_vld = 1'b0;
    total++; if (fifo_level !== 3'd3) begin bad++; $display("FAIL rmid_pre got=%0d exp=3", fifo_level); end
    reset = 1'b1;
    #1;
    total++; if (bus.act_vld !== 1'b0 || fifo_level !== 3'd0 || drop_cnt !== 16'd0) begin
      bad++; $display("FAIL rmid_async got=%0b/%0d/%0d exp=0/0/0", bus.act_vld, fifo_level, drop_cnt); end
    step;
    reset = 1'b0;
    for (int i = 0; i < 16; i++) exp_tab[i] = 8'(i);
    step;
    step;
    total++; if (bus.act_vld !== 1'b0) begin bad++; $display("FAIL rmid_inflight got=%0b exp=0", bus.act_vld); end
    bus.act_rdy = 1'b1;
    bus.idx_vld = 1'b1; bus.idx = 4'd3;
    step;
    bus.idx = 4'd9;
    step;
    bus.idx_vld = 1'b0;
    total++; if (bus.act_idx !== 4'd3 || bus.act_data !== 8'h03) begin
      bad++; $display("FAIL rmid_tbl3 got=%0h/%0h exp=3/03", bus.act_idx, bus.act_data); end
    step;
    total++; if (bus.act_idx !== 4'd9 || bus.act_data !== 8'h09) begin
      bad++; $display("FAIL rmid_tbl9 got=%0h/%0h exp=9/09", bus.act_idx, bus.act_data); end
    step;
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1;
    cfg_wr_en = 1'b0; cfg_addr = 4'd0; cfg_data = 8'd0;
    bus.idx_vld = 1'b0; bus.idx = 4'd0; bus.act_rdy = 1'b0;
    for (int i = 0; i < 16; i++) exp_tab[i] = 8'(i);
    step;
    step;
    test_reset;
    test_table;
    test_overflow;
    test_full_pushpop;
    test_streaming;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cam_action_stage.md
Name: cam_action_stage

Overview:
- Stage directly downstream of the 4-bit CAM lookup.
- Consumes each valid match index, reads a 16-entry programmable action table and buffers {index, action} results in a small FIFO.
- Presents results to the forwarding logic over a valid/ready handshake.
- Decouples the fixed-rate CAM pipeline, which cannot stall, from a back-pressuring consumer; overflow is counted and results are dropped.

Parameters:
- ACT_W, 8, width of one action word.
- FIFO_DEPTH, 4, result FIFO entries; power of two, 2..16.
- CNT_W, 16, width of the saturating drop counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- idx_vld  in  1  match index valid; driven by the CAM's cam_out_vld.
- idx  in  4  match index; driven by the CAM's cam_out.
- cfg_wr_en  in  1  action table write strobe.
- cfg_addr  in  4  action table write address.
- cfg_data  in  ACT_W  action table write data.
- act_vld  out  1  head-of-FIFO result valid.
- act_idx  out  4  head-of-FIFO match index.
- act_data  out  ACT_W  head-of-FIFO action word.
- act_rdy  in  1  consumer accepts the head entry.
- fifo_level  out  clog2(FIFO_DEPTH)+1  current occupancy.
- drop_cnt  out  CNT_W  count of results dropped on overflow; saturates.

Behaviour:
- Reset, asynchronous, active-high, all state immediate:
  - action table entry i = i, zero-extended to ACT_W;
  - FIFO pointers and level = 0;
  - lookup stage valid = 0;
  - act_vld = 0, act_idx = 0, act_data = 0;
  - drop_cnt = 0.
- Reset asserted mid-operation discards all buffered and in-flight results. The first result after reset release comes from an idx_vld sampled on or after the first clock edge with reset low.
- Stage L (lookup), one register stage:
  - On an edge with idx_vld = 1, capture idx and table[idx] into the L register and set L_vld = 1.
  - On an edge with idx_vld = 0, set L_vld = 0.
  - A new index may arrive every cycle; the stage never stalls.
- Table write: on an edge with cfg_wr_en = 1, table[cfg_addr] <= cfg_data.
- Same-edge write and lookup of the same address: the lookup captures the OLD entry. The new value is visible to lookups sampled on later edges.
- Stage F (FIFO), first-word-fall-through:
  - act_vld = (level != 0);
  - act_idx and act_data always show the head entry; they show 0 when empty.
  - pop = act_vld & act_rdy.
  - push = L_vld, accepted when level < FIFO_DEPTH, or when level == FIFO_DEPTH and pop = 1 in the same cycle.
  - Simultaneous push and pop: level is unchanged and order is preserved. When full, the popped slot is reused; no drop occurs.
  - Push refused (full, no pop): the result is discarded and drop_cnt increments by 1, saturating at 2^CNT_W-1.
  - Pointers wrap modulo FIFO_DEPTH. level is tracked explicitly, so full and empty are unambiguous.
- Latency and ordering:
  - idx_vld sampled at edge N into an empty FIFO gives act_vld = 1 after edge N+1, i.e. two register stages from the input.
  - Results leave in arrival order.
  - act_rdy while act_vld = 0 has no effect.
- Head stability: act_idx and act_data do not change while act_vld = 1 and act_rdy = 0.

Test Plan:
- Reset defaults: release reset, send idx = 5, act_rdy = 1 → act_vld one cycle later (2 edges after sampling), act_idx = 5, act_data = 0x05; drop_cnt = 0, fifo_level returns to 0.
- Table programming: write cfg_addr = 3, cfg_data = 0xA7. Next cycle send idx = 3 → act_data = 0xA7. Same-edge write of addr 9 = 0x11 with idx = 9 → act_data = 0x09; a following idx = 9 → 0x11.
- Back-pressure and overflow, FIFO_DEPTH = 4, act_rdy = 0: send idx 0..5 back-to-back → fifo_level = 4, drop_cnt = 2. Raise act_rdy → indices 0,1,2,3 delivered in order, then act_vld = 0.
- Full with simultaneous push/pop: hold FIFO at 4 entries, assert act_rdy for one cycle while a new idx = 7 arrives → level stays 4, drop_cnt unchanged, 7 delivered last.
- Streaming: act_rdy = 1, idx_vld every cycle for 32 cycles → 32 results in order, fifo_level ≤ 1, drop_cnt = 0.
- Reset mid-stream: assert reset while the FIFO holds 3 entries and L_vld = 1 → act_vld = 0, fifo_level = 0, drop_cnt = 0 immediately. Table reads back default i after release.
